// File: rtl/frame_serializer_pkg.sv
// frame_serializer_pkg: shared constants, FSM state type and index-width helper
// for the frame serializer slice.
package frame_serializer_pkg;

   localparam int unsigned FRAME_WORDS = 33;
   localparam int unsigned WORD_WIDTH  = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Bits needed to address 0..depth-1 (at least one bit).
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/frame_serializer_shadow.sv
// frame_serializer_shadow: one-frame holding buffer with a full flag.
// Filled by i_load, emptied by i_take; both never occur on the same edge.
module frame_serializer_shadow
   import frame_serializer_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_WIDTH,
   parameter int unsigned DEPTH = FRAME_WORDS
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_load,
   input  logic [DEPTH-1:0][WIDTH-1:0]  i_frame,
   input  logic                         i_take,
   output logic                         o_full,
   output logic [DEPTH-1:0][WIDTH-1:0]  o_frame
);

   logic                        r_full;
   logic [DEPTH-1:0][WIDTH-1:0] r_frame;

   // Full flag: set by a load, cleared when the top takes the frame.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_full <= 1'b1;
      end else if (i_take) begin
         r_full <= 1'b0;
      end
   end

   // Frame storage: capture on load, contents only meaningful while full.
   always_ff @(posedge i_clk) begin
      if (i_load) begin
         r_frame <= i_frame;
      end
   end

   assign o_full  = r_full;
   assign o_frame = r_frame;

endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: parallel-in, serial-out frame serializer. Captures a whole
// frame in one transfer and emits it word 0 first with SOF/EOF and an index.
// Optional feature macro: FRAME_SERIALIZER_DOUBLE_BUF_EN adds a shadow frame
// buffer so the next frame can be loaded while the current one is sent.
module frame_serializer
   import frame_serializer_pkg::*;
#(
   parameter  int unsigned WIDTH = WORD_WIDTH,
   parameter  int unsigned DEPTH = FRAME_WORDS,
   localparam int unsigned IW    = idx_width(DEPTH)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [DEPTH-1:0][WIDTH-1:0]  i_frame_in,
   input  logic                         i_load_valid,
   output logic                         o_load_ready,
   output logic [WIDTH-1:0]             o_q,
   output logic                         o_q_valid,
   input  logic                         i_q_ready,
   output logic [IW-1:0]                o_index,
   output logic                         o_sof,
   output logic                         o_eof
);

   localparam logic [IW-1:0] LAST_IDX   = IW'(DEPTH - 1);
   localparam logic [IW-1:0] PENULT_IDX = IW'(DEPTH - 2);

   state_t                      r_state;
   logic                        r_valid;
   logic                        r_sof;
   logic                        r_eof;
   logic                        r_load_ready;
   logic [IW-1:0]               r_index;
   logic [DEPTH-1:0][WIDTH-1:0] r_buf;

   logic                        w_load;
   logic                        w_beat;
   logic                        w_last;
   logic                        w_load_active;
   logic                        w_take;
   logic                        w_next_frame;
   logic                        w_next_ready;
   logic [DEPTH-1:0][WIDTH-1:0] w_shadow_frame;

   assign w_load = i_load_valid && r_load_ready;
   assign w_beat = r_valid && i_q_ready;
   assign w_last = (r_index == LAST_IDX);

`ifdef FRAME_SERIALIZER_DOUBLE_BUF_EN
   logic w_eof_hs;
   logic w_shadow_full;
   logic w_shadow_load;

   assign w_eof_hs      = w_beat && w_last;
   // A load bypasses the shadow when nothing is being sent or when it
   // coincides with the EOF handshake and the shadow is empty.
   assign w_load_active = w_load && ((r_state == IDLE) || (w_eof_hs && !w_shadow_full));
   assign w_shadow_load = w_load && !w_load_active;
   assign w_take        = w_eof_hs && w_shadow_full;
   assign w_next_frame  = w_shadow_full || w_load;
   assign w_next_ready  = !(w_shadow_load || (w_shadow_full && !w_take));

   frame_serializer_shadow #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_shadow (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_shadow_load),
      .i_frame (i_frame_in),
      .i_take  (w_take),
      .o_full  (w_shadow_full),
      .o_frame (w_shadow_frame)
   );
`else
   assign w_load_active  = w_load;
   assign w_take         = 1'b0;
   assign w_next_frame   = 1'b0;
   assign w_shadow_frame = '0;
   // Ready follows IDLE one cycle late, so IDLE always lasts a full cycle
   // before the next frame can be accepted.
   assign w_next_ready   = (r_state == IDLE) && !w_load;
`endif

   // Control FSM with registered valid, index, SOF/EOF and load-ready.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_valid      <= 1'b0;
         r_index      <= '0;
         r_sof        <= 1'b0;
         r_eof        <= 1'b0;
         r_load_ready <= 1'b0;
      end else begin
         r_load_ready <= w_next_ready;
         case (r_state)
            IDLE: begin
               if (w_load) begin
                  r_state <= SEND;
                  r_valid <= 1'b1;
                  r_index <= '0;
                  r_sof   <= 1'b1;
                  r_eof   <= 1'b0;
               end
            end
            SEND: begin
               if (w_beat) begin
                  if (!w_last) begin
                     r_index <= r_index + 1'b1;
                     r_sof   <= 1'b0;
                     r_eof   <= (r_index == PENULT_IDX);
                  end else if (w_next_frame) begin
                     r_index <= '0;
                     r_sof   <= 1'b1;
                     r_eof   <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                     r_index <= '0;
                     r_sof   <= 1'b0;
                     r_eof   <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   // Active frame buffer: refilled from the shadow or directly from the input.
   always_ff @(posedge i_clk) begin
      if (w_take) begin
         r_buf <= w_shadow_frame;
      end else if (w_load_active) begin
         r_buf <= i_frame_in;
      end
   end

   assign o_q          = r_valid ? r_buf[r_index] : '0;
   assign o_q_valid    = r_valid;
   assign o_index      = r_index;
   assign o_sof        = r_sof;
   assign o_eof        = r_eof;
   assign o_load_ready = r_load_ready;

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed bench for frame_serializer (both builds).
module tb_frame_serializer;
   import frame_serializer_pkg::*;

   localparam int W  = WORD_WIDTH;
   localparam int D  = FRAME_WORDS;
   localparam int IW = idx_width(D);
`ifdef FRAME_SERIALIZER_DOUBLE_BUF_EN
   localparam int EXP_GAP = 0;
`else
   localparam int EXP_GAP = 2;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [D-1:0][W-1:0]  frame_in;
   logic                 load_valid;
   logic                 load_ready;
   logic [W-1:0]         q;
   logic                 q_valid;
   logic                 q_ready;
   logic [IW-1:0]        index;
   logic                 sof;
   logic                 eof;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   frame_serializer #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_frame_in   (frame_in),
      .i_load_valid (load_valid),
      .o_load_ready (load_ready),
      .o_q          (q),
      .o_q_valid    (q_valid),
      .i_q_ready    (q_ready),
      .o_index      (index),
      .o_sof        (sof),
      .o_eof        (eof)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_frame(input logic [7:0] base);
      for (int i = 0; i < D; i++) frame_in[i] = base + 8'(i);
   endtask

   task automatic wait_ready;
      for (int c = 0; c < 20 && !load_ready; c++) tick;
      vectors++;
      if (load_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL wait_ready: load_ready=%b required 1 within 20 cycles", load_ready);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; load_valid = 1'b0; q_ready = 1'b0; set_frame(8'h00);
      tick; tick;
      vectors++;
      if ({q_valid, q, index, sof, eof} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: valid=%b q=%h idx=%0d sof=%b eof=%b required all 0",
                  q_valid, q, index, sof, eof);
      end
      vectors++;
      if (load_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: load_ready=%b required 0", load_ready);
      end
      #2 rst = 1'b0;
      tick;
      vectors++;
      if (load_ready !== 1'b1 || q_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset: load_ready=%b valid=%b required 1/0", load_ready, q_valid);
      end
   endtask

   task automatic test_single_frame;
      logic [W+IW+2:0] obs, exp;
      wait_ready;
      set_frame(8'h00); q_ready = 1'b1; load_valid = 1'b1;
      tick;
      load_valid = 1'b0;
      for (int i = 0; i < D; i++) begin
         obs = {q_valid, q, index, sof, eof};
         exp = {1'b1, 8'(i), IW'(i), (i == 0), (i == D - 1)};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL single_word%0d: {v,q,idx,sof,eof}=%h required %h", i, obs, exp);
         end
         tick;
      end
      vectors++;
      if (q_valid !== 1'b0 || index !== '0) begin
         miscompares++;
         $display("FAIL single_after_eof: valid=%b idx=%0d required 0/0", q_valid, index);
      end
`ifndef FRAME_SERIALIZER_DOUBLE_BUF_EN
      vectors++;
      if (load_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_bubble_ready: load_ready=%b required 0", load_ready);
      end
`endif
   endtask

   task automatic test_stall;
      int k = 0;
      int stall = 0;
      wait_ready;
      set_frame(8'h00); q_ready = 1'b1; load_valid = 1'b1;
      tick;
      load_valid = 1'b0;
      for (int c = 0; c < 100 && k < D; c++) begin
         vectors++;
         if (q_valid !== 1'b1 || q !== 8'(k) || index !== IW'(k)) begin
            miscompares++;
            $display("FAIL stall_word%0d: valid=%b q=%h idx=%0d required 1/%h/%0d",
                     k, q_valid, q, index, 8'(k), k);
         end
         if (k == 5 && stall < 3) begin
            q_ready = 1'b0; stall++;
         end else begin
            q_ready = 1'b1; k++;
         end
         tick;
      end
      vectors++;
      if (k !== D || q_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_complete: words=%0d valid=%b required %0d/0", k, q_valid, D);
      end
   endtask

   task automatic test_back_to_back;
      int k = 0;
      int gap = 0;
      logic pending;
      logic [7:0] exp_q;
      wait_ready;
      set_frame(8'h00); q_ready = 1'b1; load_valid = 1'b1;
      tick;
      set_frame(8'h80);
      for (int c = 0; c < 300 && k < 2 * D; c++) begin
         pending = load_valid && load_ready;
         if (q_valid) begin
            exp_q = (k < D) ? 8'(k) : 8'h80 + 8'(k - D);
            vectors++;
            if (q !== exp_q || index !== IW'(k % D)) begin
               miscompares++;
               $display("FAIL b2b_word%0d: q=%h idx=%0d required %h/%0d", k, q, index, exp_q, k % D);
            end
            if (k == D) begin
               vectors++;
               if (gap !== EXP_GAP) begin
                  miscompares++;
                  $display("FAIL b2b_gap: idle cycles=%0d required %0d", gap, EXP_GAP);
               end
            end
            k++;
         end else if (k >= D) begin
            gap++;
         end else if (k > 0) begin
            vectors++; miscompares++;
            $display("FAIL b2b_valid_drop: valid=0 at word %0d required 1", k);
         end
         tick;
         if (pending) load_valid = 1'b0;
      end
      vectors++;
      if (k !== 2 * D) begin
         miscompares++;
         $display("FAIL b2b_count: words=%0d required %0d", k, 2 * D);
      end
      tick;
   endtask

   task automatic test_reset_mid;
      wait_ready;
      set_frame(8'h00); q_ready = 1'b1; load_valid = 1'b1;
      tick;
      load_valid = 1'b0;
      for (int c = 0; c < 40 && index != IW'(10); c++) tick;
      rst = 1'b1;
      #1;
      vectors++;
      if ({q_valid, q, index, sof, eof, load_ready} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid: valid=%b q=%h idx=%0d sof=%b eof=%b rdy=%b required all 0",
                  q_valid, q, index, sof, eof, load_ready);
      end
      #2 rst = 1'b0;
      wait_ready;
      set_frame(8'h40); load_valid = 1'b1;
      tick;
      load_valid = 1'b0;
      vectors++;
      if (q_valid !== 1'b1 || q !== 8'h40 || index !== '0 || sof !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_restart: valid=%b q=%h idx=%0d sof=%b required 1/40/0/1",
                  q_valid, q, index, sof);
      end
      repeat (D) tick;
      vectors++;
      if (q_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_restart_end: valid=%b required 0", q_valid);
      end
      tick;
   endtask

`ifdef FRAME_SERIALIZER_DOUBLE_BUF_EN
   task automatic test_shadow;
      int k = 0;
      logic pending;
      logic [7:0] exp_q;
      wait_ready;
      set_frame(8'h00); q_ready = 1'b0; load_valid = 1'b1;
      tick;
      set_frame(8'h80);
      tick;
      vectors++;
      if (load_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL shadow_full_ready: load_ready=%b required 0", load_ready);
      end
      set_frame(8'h40); q_ready = 1'b1;
      for (int c = 0; c < 400 && k < 3 * D; c++) begin
         pending = load_valid && load_ready;
         if (pending) begin
            vectors++;
            if (k < D) begin
               miscompares++;
               $display("FAIL shadow_holdoff: third load accepted at word %0d required >= %0d", k, D);
            end
         end
         if (q_valid) begin
            exp_q = (k < D) ? 8'(k) : (k < 2 * D) ? 8'h80 + 8'(k - D) : 8'h40 + 8'(k - 2 * D);
            vectors++;
            if (q !== exp_q || index !== IW'(k % D)) begin
               miscompares++;
               $display("FAIL shadow_word%0d: q=%h idx=%0d required %h/%0d", k, q, index, exp_q, k % D);
            end
            k++;
         end else begin
            vectors++; miscompares++;
            $display("FAIL shadow_valid_drop: valid=0 at word %0d required 1", k);
         end
         tick;
         if (pending) load_valid = 1'b0;
      end
      vectors++;
      if (k !== 3 * D || q_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL shadow_count: words=%0d valid=%b required %0d/0", k, q_valid, 3 * D);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_single_frame;
      test_stall;
      test_back_to_back;
      test_reset_mid;
`ifdef FRAME_SERIALIZER_DOUBLE_BUF_EN
      test_shadow;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
